// File: rtl/cic_pkg.sv
// cic_pkg: shared constants and helpers for the CIC decimator.
//   CIC_R, CIC_N : default decimation ratio and stage count
//   cic_acc_w()  : accumulator width needed for a lossless (wrapping) CIC
//   cic_shift()  : right shift that normalises the DC gain R^N back to 1
//   acc_t        : accumulator type at the default configuration
package cic_pkg;

  localparam int CIC_R = 8;
  localparam int CIC_N = 3;

  // Bit growth of an N-stage, M=1 CIC is N*log2(R); R is a power of two.
  function automatic int cic_acc_w(input int in_w, input int r, input int n);
    return in_w + n * $clog2(r);
  endfunction

  function automatic int cic_shift(input int r, input int n);
    return n * $clog2(r);
  endfunction

  localparam int CIC_ACC_W = cic_acc_w(16, CIC_R, CIC_N);
  localparam int CIC_SHIFT = cic_shift(CIC_R, CIC_N);

  typedef logic signed [CIC_ACC_W-1:0] acc_t;

endpackage

// File: rtl/cic_comb_stage.sv
// cic_comb_stage: one registered differentiator (y = x - x_delayed, M=1)
// with a valid bit. The delay and output only advance when in_valid is set.
//   clk, reset : clock, asynchronous active-high reset
//   x, in_valid : input word and its qualifier
//   y, out_valid : registered difference, valid for one cycle per input
module cic_comb_stage #(
  parameter int W = 25
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] x,
  input  logic         in_valid,
  output logic [W-1:0] y,
  output logic         out_valid
);

  logic [W-1:0] delay_r;
  logic [W-1:0] y_r;
  logic         valid_r;

  // Differentiator state; wrapping subtraction is intentional.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      delay_r <= '0;
      y_r     <= '0;
      valid_r <= 1'b0;
    end else begin
      valid_r <= in_valid;
      if (in_valid) begin
        y_r     <= x - delay_r;
        delay_r <= x;
      end
    end
  end

  assign y         = y_r;
  assign out_valid = valid_r;

endmodule

// File: rtl/cic_decim.sv
// cic_decim: N-stage CIC decimator (integrators, downsample by R, combs),
// output normalised by an arithmetic right shift of N*log2(R).
//   clk       : system clock
//   reset     : asynchronous active-high reset
//   x_in      : signed input sample, accepted when in_valid=1
//   in_valid  : input strobe
//   y_out     : signed decimated sample, held between out_valid pulses
//   out_valid : one-cycle pulse when y_out is new
// Optional build macro CIC_ROUND_EN: round half up before the shift,
// saturate to OUT_W, and keep a sticky internal flag sat_seen.
module cic_decim
  import cic_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 16,
  parameter int R     = CIC_R,
  parameter int N     = CIC_N,
  parameter int ACC_W = cic_acc_w(IN_W, R, N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  x_in,
  input  logic             in_valid,
  output logic [OUT_W-1:0] y_out,
  output logic             out_valid
);

  localparam int SHIFT = cic_shift(R, N);
  localparam int CNT_W = $clog2(R);

  logic [ACC_W-1:0] x_ext_s;
  logic [ACC_W-1:0] integ_r [N];
  logic [CNT_W-1:0] cnt_r;
  logic             strobe_r;
  logic [ACC_W-1:0] comb_in_r;
  logic             comb_in_v_r;
  logic [ACC_W-1:0] comb_x_s [N+1];
  logic             comb_v_s [N+1];
  logic [OUT_W-1:0] y_next_s;

  assign x_ext_s = {{(ACC_W-IN_W){x_in[IN_W-1]}}, x_in};

  // Integrator k adds the registered output of stage k-1, so the cascade
  // carries N-1 cycles of internal skew; the combs see that as pure delay.
  for (genvar k = 0; k < N; k++) begin : g_integ
    if (k == 0) begin : g_first
      // First integrator accumulates the sign-extended input.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          integ_r[k] <= '0;
        end else if (in_valid) begin
          integ_r[k] <= integ_r[k] + x_ext_s;
        end
      end
    end else begin : g_rest
      // Later integrators accumulate the previous stage's register.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          integ_r[k] <= '0;
        end else if (in_valid) begin
          integ_r[k] <= integ_r[k] + integ_r[k-1];
        end
      end
    end
  end

  // Sample counter; accepting the R-th sample of a group raises the strobe
  // for exactly the following cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r    <= '0;
      strobe_r <= 1'b0;
    end else begin
      strobe_r <= in_valid & (cnt_r == CNT_W'(R - 1));
      if (in_valid) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  // Downsampler: capture the last integrator when the strobe is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      comb_in_r   <= '0;
      comb_in_v_r <= 1'b0;
    end else begin
      comb_in_v_r <= strobe_r;
      if (strobe_r) begin
        comb_in_r <= integ_r[N-1];
      end
    end
  end

  assign comb_x_s[0] = comb_in_r;
  assign comb_v_s[0] = comb_in_v_r;

  for (genvar k = 0; k < N; k++) begin : g_comb
    cic_comb_stage #(.W(ACC_W)) u_comb (
      .clk       (clk),
      .reset     (reset),
      .x         (comb_x_s[k]),
      .in_valid  (comb_v_s[k]),
      .y         (comb_x_s[k+1]),
      .out_valid (comb_v_s[k+1])
    );
  end

`ifdef CIC_ROUND_EN
  localparam logic [ACC_W:0] HALF = {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);

  logic signed [ACC_W:0] rounded_s;
  logic                  pos_ovf_s;
  logic                  neg_ovf_s;
  logic                  sat_seen;

  // Round half up, shift, and clamp to the OUT_W range. One guard bit
  // keeps the rounding add from wrapping.
  always_comb begin
    rounded_s = ($signed({comb_x_s[N][ACC_W-1], comb_x_s[N]}) + $signed(HALF)) >>> SHIFT;
    pos_ovf_s = ~rounded_s[ACC_W] & (|rounded_s[ACC_W-1:OUT_W-1]);
    neg_ovf_s = rounded_s[ACC_W] & ~(&rounded_s[ACC_W-1:OUT_W-1]);
    y_next_s  = rounded_s[OUT_W-1:0];
    if (pos_ovf_s) begin
      y_next_s = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (neg_ovf_s) begin
      y_next_s = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      y_next_s = rounded_s[OUT_W-1:0];
    end
  end

  // Sticky saturation flag, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_seen <= 1'b0;
    end else if (comb_v_s[N] & (pos_ovf_s | neg_ovf_s)) begin
      sat_seen <= 1'b1;
    end
  end
`else
  // Floor scaling: arithmetic shift then truncate to OUT_W.
  always_comb begin
    y_next_s = OUT_W'($signed(comb_x_s[N]) >>> SHIFT);
  end
`endif

  // Output register: y_out holds between pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_out     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= comb_v_s[N];
      if (comb_v_s[N]) begin
        y_out <= y_next_s;
      end
    end
  end

endmodule

// File: tb/tb_cic_decim.sv
// tb_cic_decim: scoreboard bench for cic_decim at default parameters.
// Stimulus pushes an expected (due cycle, value, tolerance) entry for each
// R-th accepted sample; a monitor pops and compares on every out_valid.
// Expected values are hand-derived: for a constant input c starting from
// cleared state, the first three outputs are c*56/512, c*392/512, then c.
module tb_cic_decim;

  logic        clk;
  logic        reset;
  logic [15:0] x_in;
  logic        in_valid;
  logic [15:0] y_out;
  logic        out_valid;

  cic_decim dut (
    .clk       (clk),
    .reset     (reset),
    .x_in      (x_in),
    .in_valid  (in_valid),
    .y_out     (y_out),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int due;
    int val;
    int tol;
    bit chk;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int acc_cnt = 0;
  int mode = 0;      // 0: constant input, 1: alternating input
  int last_exp = 0;

  // Hand-derived scaling of a full-precision comb result.
  function automatic int scale(input longint p);
    longint r;
`ifdef CIC_ROUND_EN
    r = (p + 64'sd256) >>> 9;
    if (r > 64'sd32767) r = 64'sd32767;
    if (r < -64'sd32768) r = -64'sd32768;
`else
    r = p >>> 9;
`endif
    return int'(r);
  endfunction

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic feed(input int v, input int gap);
    exp_t e;
    int grp;
    int tap;
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    x_in = v[15:0];
    in_valid = 1'b1;
    if (acc_cnt % 8 == 7) begin
      grp = acc_cnt / 8;
      e.due = cyc + 1 + 5;
      if (mode == 0) begin
        tap = (grp == 0) ? 56 : ((grp == 1) ? 392 : 512);
        e.val = scale(longint'(tap) * longint'(v));
        e.tol = 0;
        e.chk = 1'b1;
        last_exp = e.val;
      end else begin
        e.val = 0;
        e.tol = 1;
        e.chk = (grp >= 2);
      end
      q.push_back(e);
    end
    acc_cnt++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    #1;
    check("rst_y_out", int'(y_out), 0);
    check("rst_out_valid", int'(out_valid), 0);
    q.delete();
    acc_cnt = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drain(input string name);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 60 && q.size() > 0; i++) @(negedge clk);
    check({name, "_pending"}, q.size(), 0);
    q.delete();
    repeat (20) @(negedge clk);
  endtask

  // Monitor: compare every out_valid pulse with the oldest expectation.
  initial begin
    exp_t e;
    int yv;
    forever begin
      @(negedge clk);
      if (!reset && out_valid) begin
        yv = int'($signed(y_out));
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexp_out: got out_valid with y_out %0d at cycle %0d, expected none", yv, cyc);
        end else begin
          e = q.pop_front();
          check("out_timing", cyc, e.due);
          if (e.chk) begin
            total++;
            if (yv > e.val + e.tol || yv < e.val - e.tol) begin
              bad++;
              $display("FAIL y_value: got %0d expected %0d (+-%0d) at cycle %0d", yv, e.val, e.tol, cyc);
            end
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    x_in = 16'd0;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("init_y_out", int'(y_out), 0);
    check("init_out_valid", int'(out_valid), 0);
    reset = 1'b0;

    // DC, continuous strobes
    mode = 0;
    for (int i = 0; i < 200; i++) feed(1000, 0);
    drain("dc");
    check("dc_hold", int'($signed(y_out)), last_exp);

    // Reset mid-group: partial count must be discarded
    for (int i = 0; i < 5; i++) feed(1000, 0);
    do_reset();
    for (int i = 0; i < 8; i++) feed(500, 0);
    drain("midrst");
    check("midrst_hold", int'($signed(y_out)), scale(64'sd56 * 64'sd500));

    // Sparse strobes: every third cycle
    do_reset();
    for (int i = 0; i < 64; i++) feed(200, 2);
    drain("sparse");
    check("sparse_hold", int'($signed(y_out)), 200);

    // Full scale positive and negative (integrators wrap)
    do_reset();
    for (int i = 0; i < 20000; i++) feed(32767, 0);
    drain("fs_pos");
    check("fs_pos_hold", int'($signed(y_out)), 32767);
    do_reset();
    for (int i = 0; i < 20000; i++) feed(-32768, 0);
    drain("fs_neg");
    check("fs_neg_hold", int'($signed(y_out)), -32768);

    // Nyquist: alternating +-16384 lands in the CIC null
    do_reset();
    mode = 1;
    for (int i = 0; i < 200; i++) feed((i % 2 == 0) ? 16384 : -16384, 0);
    drain("nyq");

    // DC of -1 exercises floor versus round-half-up
    do_reset();
    mode = 0;
    for (int i = 0; i < 64; i++) feed(-1, 0);
    drain("dc_m1");
    check("dc_m1_hold", int'($signed(y_out)), scale(-64'sd512));
`ifdef CIC_ROUND_EN
    check("sat_seen", int'(dut.sat_seen), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
